// File: rtl/alu_mc_pkg.sv
// rtl/alu_mc_pkg.sv - shared opcodes, state encoding and iterator modes for alu_mc
package alu_mc_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_RSV  = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;
  localparam logic [2:0] OP_MULU = 3'b110;
  localparam logic [2:0] OP_DIVU = 3'b111;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mc_iter.sv
// rtl/alu_mc_iter.sv - shared shift/accumulate datapath: radix-2 unsigned multiply or restoring divide
// {hi,lo} holds the running product (MUL) or remainder/quotient (DIV); one bit per step.
module alu_mc_iter
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [WIDTH-1:0] b_q;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  always_comb begin
    add_sum = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
    shifted = {hi, lo[WIDTH-1]};
    // remainder < B keeps shifted below 2B, so trial's MSB is a clean borrow flag
    trial   = shifted - {1'b0, b_q};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi  <= '0;
      lo  <= '0;
      b_q <= '0;
    end else if (load) begin
      hi  <= '0;
      lo  <= A;
      b_q <= B;
    end else if (step) begin
      if (mode == MODE_MUL) begin
        hi <= add_sum[WIDTH:1];
        lo <= {add_sum[0], lo[WIDTH-1:1]};
      end else if (!trial[WIDTH]) begin
        hi <= trial[WIDTH-1:0];
        lo <= {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi <= shifted[WIDTH-1:0];
        lo <= {lo[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU with start/busy/done handshake and iterative MULU/DIVU
// Optional signed-overflow output V enabled by defining ALU_MC_OVERFLOW_EN.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ALUSrc,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] signimm,
  input  logic [WIDTH-1:0] RD1,
  input  logic [WIDTH-1:0] RD2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             Z
`ifdef ALU_MC_OVERFLOW_EN
  ,
  output logic             V
`endif
);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic             sel_iter;
  logic [WIDTH-1:0] res_q, hi_q;
  logic             z_q;
  logic [WIDTH-1:0] opb, sum, dif, sc_res, sc_hi;
  logic [WIDTH-1:0] it_hi, it_lo;
  logic             cap, iter_op, last;

  assign opb     = ALUSrc ? signimm : RD2;
  assign sum     = RD1 + opb;
  assign dif     = RD1 - opb;
  assign cap     = (state == S_IDLE) && start;
  assign iter_op = (ALUControl == OP_MULU) || ((ALUControl == OP_DIVU) && (opb != '0));
  assign last    = (state == S_CALC) && (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    sc_res = '0;
    sc_hi  = '0;
    case (ALUControl)
      OP_ADD:  sc_res = sum;
      OP_SUB:  sc_res = dif;
      OP_AND:  sc_res = RD1 & opb;
      OP_OR:   sc_res = RD1 | opb;
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(RD1) < $signed(opb))};
      OP_DIVU: begin
        sc_res = '1;
        sc_hi  = RD1;
      end
      default: sc_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = iter_op ? S_CALC : S_FIN;
      S_CALC:  if (last) state_nx = S_FIN;
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      op_q     <= OP_ADD;
      sel_iter <= 1'b0;
      res_q    <= '0;
      hi_q     <= '0;
      z_q      <= 1'b0;
    end else if (cap) begin
      cnt      <= '0;
      op_q     <= ALUControl;
      sel_iter <= 1'b0;
      if (!iter_op) begin
        res_q <= sc_res;
        hi_q  <= sc_hi;
        z_q   <= (sc_res == '0);
      end
    end else if (state == S_CALC) begin
      cnt <= cnt + 1'b1;
      // outputs switch to the iterator only once its last step has landed
      if (last) sel_iter <= 1'b1;
    end
  end

  alu_mc_iter #(.WIDTH(WIDTH)) u_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .mode  ((op_q == OP_DIVU) ? MODE_DIV : MODE_MUL),
    .load  (cap && iter_op),
    .step  (state == S_CALC),
    .A     (RD1),
    .B     (opb),
    .hi    (it_hi),
    .lo    (it_lo)
  );

  assign busy   = (state != S_IDLE);
  assign done   = (state == S_FIN);
  assign result = sel_iter ? it_lo : res_q;
  assign hi     = sel_iter ? it_hi : hi_q;
  assign Z      = sel_iter ? (it_lo == '0) : z_q;

`ifdef ALU_MC_OVERFLOW_EN
  logic v_q, sc_v;

  always_comb begin
    sc_v = 1'b0;
    if (ALUControl == OP_ADD)
      sc_v = (RD1[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != RD1[WIDTH-1]);
    else if (ALUControl == OP_SUB)
      sc_v = (RD1[WIDTH-1] == ~opb[WIDTH-1]) && (dif[WIDTH-1] != RD1[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                v_q <= 1'b0;
    else if (cap && !iter_op)  v_q <= sc_v;
  end

  assign V = sel_iter ? ((op_q == OP_MULU) && (it_hi != '0)) : v_q;
`endif

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - self-checking bench for alu_mc: vector table, corner sequences, random vs model
module tb_alu_mc;
  import alu_mc_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n, start, ALUSrc;
  logic [2:0]   ALUControl;
  logic [W-1:0] signimm, RD1, RD2;
  logic         busy, done, Z;
  logic [W-1:0] result, hi;
`ifdef ALU_MC_OVERFLOW_EN
  logic         V;
`endif

  alu_mc #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .ALUSrc     (ALUSrc),
    .ALUControl (ALUControl),
    .signimm    (signimm),
    .RD1        (RD1),
    .RD2        (RD2),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .hi         (hi),
    .Z          (Z)
`ifdef ALU_MC_OVERFLOW_EN
    ,
    .V          (V)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic [W-1:0] h, output logic z,
                                output logic v, output int lat);
    longint s;
    longint unsigned p;
    r = '0; h = '0; v = 1'b0; lat = 1;
    case (op)
      3'd0: begin
        s = longint'($signed(a)) + longint'($signed(b));
        r = a + b;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd1: begin
        s = longint'($signed(a)) - longint'($signed(b));
        r = a - b;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: begin
        p = 64'(a) * 64'(b);
        r = p[31:0];
        h = p[63:32];
        v = (h != 0);
        lat = W + 1;
      end
      3'd7: begin
        if (b == 0) begin
          r = '1;
          h = a;
        end else begin
          r = a / b;
          h = a % b;
          lat = W + 1;
        end
      end
      default: r = '0;
    endcase
    z = (r == 0);
  endfunction

  task automatic run_op(input logic [2:0] op, input logic src, input logic [W-1:0] a,
                        input logic [W-1:0] b2, input logic [W-1:0] imm,
                        output logic [W-1:0] r, output logic [W-1:0] h, output logic z,
                        output logic v, output int lat);
    @(negedge clk);
    ALUControl = op; ALUSrc = src; RD1 = a; RD2 = b2; signimm = imm; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    RD1 = $urandom; RD2 = $urandom; signimm = $urandom; ALUControl = 3'($urandom);
    chk("busy_inflight", 64'(busy), 64'(1));
    lat = 1;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!done) lat = -1;
    r = result; h = hi; z = Z;
`ifdef ALU_MC_OVERFLOW_EN
    v = V;
`else
    v = 1'b0;
`endif
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'(0));
    chk("busy_after", 64'(busy), 64'(0));
  endtask

  typedef struct {
    logic [2:0]   op;
    logic         src;
    logic [W-1:0] a, b2, imm, er, eh;
    logic         ez;
    int           elat;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [W-1:0] r, h, mr, mh;
    logic         z, v, mz, mv;
    int           lat, mlat, pulses, dlat;
    logic [2:0]   op;
    logic         src;
    logic [W-1:0] a, b2, imm;

    tbl[0] = '{op: OP_ADD,  src: 1'b0, a: 32'd2,          b2: 32'd5,    imm: 32'd0,       er: 32'd7,          eh: 32'd0, ez: 1'b0, elat: 1};
    tbl[1] = '{op: OP_SUB,  src: 1'b0, a: 32'd5,          b2: 32'd5,    imm: 32'd0,       er: 32'd0,          eh: 32'd0, ez: 1'b1, elat: 1};
    tbl[2] = '{op: OP_AND,  src: 1'b0, a: 32'd2,          b2: 32'd5,    imm: 32'd0,       er: 32'd0,          eh: 32'd0, ez: 1'b1, elat: 1};
    tbl[3] = '{op: OP_OR,   src: 1'b0, a: 32'd2,          b2: 32'd5,    imm: 32'd0,       er: 32'd7,          eh: 32'd0, ez: 1'b0, elat: 1};
    tbl[4] = '{op: OP_SLT,  src: 1'b0, a: 32'hFFFFFFFF,   b2: 32'd5,    imm: 32'd0,       er: 32'd1,          eh: 32'd0, ez: 1'b0, elat: 1};
    tbl[5] = '{op: OP_ADD,  src: 1'b1, a: 32'd1,          b2: 32'h1234, imm: 32'h00007FFF, er: 32'h00008000,  eh: 32'd0, ez: 1'b0, elat: 1};
    tbl[6] = '{op: OP_RSV,  src: 1'b0, a: 32'd3,          b2: 32'd4,    imm: 32'd0,       er: 32'd0,          eh: 32'd0, ez: 1'b1, elat: 1};
    tbl[7] = '{op: OP_MULU, src: 1'b0, a: 32'hFFFFFFFF,   b2: 32'd2,    imm: 32'd0,       er: 32'hFFFFFFFE,   eh: 32'd1, ez: 1'b0, elat: 33};
    tbl[8] = '{op: OP_DIVU, src: 1'b0, a: 32'd100,        b2: 32'd7,    imm: 32'd0,       er: 32'd14,         eh: 32'd2, ez: 1'b0, elat: 33};
    tbl[9] = '{op: OP_DIVU, src: 1'b0, a: 32'd9,          b2: 32'd0,    imm: 32'd0,       er: 32'hFFFFFFFF,   eh: 32'd9, ez: 1'b0, elat: 1};

    rst_n = 1'b0; start = 1'b0; ALUSrc = 1'b0; ALUControl = 3'd0;
    signimm = '0; RD1 = '0; RD2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("reset_busy",   64'(busy),   64'(0));
    chk("reset_done",   64'(done),   64'(0));
    chk("reset_result", 64'(result), 64'(0));
    chk("reset_hi",     64'(hi),     64'(0));
    chk("reset_z",      64'(Z),      64'(0));

    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].op, tbl[i].src, tbl[i].a, tbl[i].b2, tbl[i].imm, r, h, z, v, lat);
      chk($sformatf("vec%0d_result", i), 64'(r),   64'(tbl[i].er));
      chk($sformatf("vec%0d_hi", i),     64'(h),   64'(tbl[i].eh));
      chk($sformatf("vec%0d_z", i),      64'(z),   64'(tbl[i].ez));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(tbl[i].elat));
`ifdef ALU_MC_OVERFLOW_EN
      model(tbl[i].op, tbl[i].a, tbl[i].src ? tbl[i].imm : tbl[i].b2, mr, mh, mz, mv, mlat);
      chk($sformatf("vec%0d_v", i), 64'(v), 64'(mv));
`endif
    end

    // start hammered every cycle during a MULU must be ignored
    @(negedge clk);
    ALUControl = OP_MULU; ALUSrc = 1'b0; RD1 = 32'hFFFFFFFF; RD2 = 32'd2; start = 1'b1;
    @(posedge clk);
    pulses = 0; dlat = -1; r = '0; h = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k <= 30) begin
        start = 1'b1; RD1 = $urandom; RD2 = $urandom; ALUControl = 3'($urandom);
      end else begin
        start = 1'b0;
      end
      if (done) begin
        pulses++;
        dlat = k; r = result; h = hi;
      end
    end
    chk("hammer_pulses",  64'(pulses), 64'(1));
    chk("hammer_latency", 64'(dlat),   64'(33));
    chk("hammer_result",  64'(r),      64'(32'hFFFFFFFE));
    chk("hammer_hi",      64'(h),      64'(1));

    // reset during CALC of a DIVU aborts with no done pulse
    @(negedge clk);
    ALUControl = OP_DIVU; ALUSrc = 1'b0; RD1 = 32'd100; RD2 = 32'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy",   64'(busy),   64'(0));
    chk("abort_done",   64'(done),   64'(0));
    chk("abort_result", 64'(result), 64'(0));
    chk("abort_hi",     64'(hi),     64'(0));
    chk("abort_z",      64'(Z),      64'(0));
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("abort_no_done", 64'(pulses), 64'(0));
    run_op(OP_ADD, 1'b0, 32'd1, 32'd1, 32'd0, r, h, z, v, lat);
    chk("after_abort_add", 64'(r), 64'(2));

    for (int i = 0; i < 60; i++) begin
      op  = 3'($urandom_range(0, 7));
      src = 1'($urandom);
      a   = $urandom;
      b2  = (i % 5 == 0) ? 32'($urandom_range(0, 50)) : $urandom;
      imm = (i % 3 == 0) ? 32'($urandom_range(0, 50)) : $urandom;
      if (op == OP_DIVU && $urandom_range(0, 3) == 0) begin
        b2 = '0; imm = '0;
      end
      model(op, a, src ? imm : b2, mr, mh, mz, mv, mlat);
      run_op(op, src, a, b2, imm, r, h, z, v, lat);
      chk($sformatf("rnd%0d_op%0d_result", i, op), 64'(r), 64'(mr));
      chk($sformatf("rnd%0d_op%0d_hi", i, op), 64'(h), 64'(mh));
      chk($sformatf("rnd%0d_op%0d_z", i, op), 64'(z), 64'(mz));
      chk($sformatf("rnd%0d_op%0d_latency", i, op), 64'(lat), 64'(mlat));
`ifdef ALU_MC_OVERFLOW_EN
      chk($sformatf("rnd%0d_op%0d_v", i, op), 64'(v), 64'(mv));
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
